// File: rtl/riego_pkg.sv
// Shared definitions for the irrigation chain: FSM states and default
// humidity thresholds, also used by the downstream pump stage.
package riego_pkg;

  typedef enum logic [2:0] {
    INACTIVO   = 3'd0,
    MUESTREO   = 3'd1,
    PULSO      = 3'd2,
    ESPERA_ACK = 3'd3,
    REPOSO     = 3'd4
  } estado_t;

  localparam int unsigned UMBRAL_BAJO_DEF = 20;
  localparam int unsigned UMBRAL_ALTO_DEF = 40;

  // Readings above 100 % are sensor glitches and never enter the average.
  localparam logic [7:0]  HUMEDAD_MAX     = 8'd100;
  localparam int unsigned N_MUESTRAS      = 4;

endpackage

// File: rtl/control_humedad_if.sv
// Sensor/pump-facing signal bundle of the humidity controller.
interface control_humedad_if;

  logic [7:0] humedad;
  logic       humedad_valida;
  logic       MODsensor;
  logic       bomba_activa;
  logic       regar;
  logic [7:0] humedad_media;
  logic       alarma;
  logic [7:0] riegos;

  modport master (
    output humedad, humedad_valida, MODsensor, bomba_activa,
    input  regar, humedad_media, alarma, riegos
  );

  modport slave (
    input  humedad, humedad_valida, MODsensor, bomba_activa,
    output regar, humedad_media, alarma, riegos
  );

endinterface

// File: rtl/promedio_humedad.sv
// Four-sample humidity averager: accumulates in-range samples and emits a
// truncated mean plus a one-cycle ready strobe the cycle after the 4th sample.
module promedio_humedad
  import riego_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activo,
  input  logic       valida,
  input  logic [7:0] muestra,
  output logic [7:0] media,
  output logic       media_lista
);

  localparam logic [2:0] CNT_LLENO = 3'(N_MUESTRAS);

  logic [9:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] media_q, media_d;
  logic       lista_q, lista_d;
  logic       acepta;

  function automatic logic [7:0] div4_trunc(input logic [9:0] suma);
    return suma[9:2];
  endfunction

  assign acepta = activo && valida && (muestra <= HUMEDAD_MAX);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    media_d = media_q;
    lista_d = 1'b0;
    if (!activo) begin
      // Leaving the sampling state discards any partial window.
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_LLENO) begin
        media_d = div4_trunc(acc_q);
        lista_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end
      if (acepta) begin
        acc_d = acc_d + {2'b00, muestra};
        cnt_d = cnt_d + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      media_q <= '0;
      lista_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      media_q <= media_d;
      lista_q <= lista_d;
    end
  end

  assign media       = media_q;
  assign media_lista = lista_q;

endmodule

// File: rtl/control_humedad.sv
// Soil-humidity irrigation controller: averages sensor samples, requests a
// watering pulse on dry soil with hysteresis, supervises pump ack and soak time.
module control_humedad
  import riego_pkg::*;
#(
  parameter int unsigned UMBRAL_BAJO   = UMBRAL_BAJO_DEF,
  parameter int unsigned UMBRAL_ALTO   = UMBRAL_ALTO_DEF,
  parameter int unsigned ACK_CICLOS    = 16,
  parameter logic [63:0] REPOSO_CICLOS = 64'd3_000_000_000
)
(
  input logic               clk,
  input logic               rst_n,
  control_humedad_if.slave  bus
);

  localparam logic [7:0]  BAJO       = 8'(UMBRAL_BAJO);
  localparam logic [7:0]  ALTO       = 8'(UMBRAL_ALTO);
  localparam logic [63:0] ACK_FIN    = 64'(ACK_CICLOS) - 64'd1;
  localparam logic [63:0] REPOSO_FIN = REPOSO_CICLOS - 64'd1;

  estado_t     estado_q, estado_d;
  logic [63:0] timer_q, timer_d;
  logic        seco_q, seco_d;
  logic        alarma_q, alarma_d;
  logic [7:0]  riegos_q, riegos_d;

  logic [7:0]  media;
  logic        media_lista;
  logic        activo;

  function automatic logic [7:0] inc_sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Samples only count while actively monitoring with the sensor present.
  assign activo = bus.MODsensor && (estado_q == MUESTREO);

  promedio_humedad u_promedio (
    .clk         (clk),
    .rst_n       (rst_n),
    .activo      (activo),
    .valida      (bus.humedad_valida),
    .muestra     (bus.humedad),
    .media       (media),
    .media_lista (media_lista)
  );

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    seco_d   = seco_q;
    alarma_d = alarma_q;
    riegos_d = riegos_q;
    if (!bus.MODsensor) begin
      estado_d = INACTIVO;
      timer_d  = '0;
    end else begin
      unique case (estado_q)
        INACTIVO: begin
          estado_d = MUESTREO;
          timer_d  = '0;
        end
        MUESTREO: begin
          if (media_lista) begin
            if (media < BAJO)       seco_d = 1'b1;
            else if (media >= ALTO) seco_d = 1'b0;
            // Once dry, keep watering until the soil reaches the upper threshold.
            if ((media < BAJO) || (seco_q && (media < ALTO)))
              estado_d = PULSO;
          end
        end
        PULSO: begin
          riegos_d = inc_sat8(riegos_q);
          timer_d  = '0;
          estado_d = ESPERA_ACK;
        end
        ESPERA_ACK: begin
          if (bus.bomba_activa) begin
            timer_d  = '0;
            estado_d = REPOSO;
          end else if (timer_q == ACK_FIN) begin
            alarma_d = 1'b1;
            timer_d  = '0;
            estado_d = REPOSO;
          end else begin
            timer_d = timer_q + 64'd1;
          end
        end
        REPOSO: begin
          if (timer_q == REPOSO_FIN) begin
            timer_d  = '0;
            estado_d = MUESTREO;
          end else begin
            timer_d = timer_q + 64'd1;
          end
        end
        default: begin
          estado_d = INACTIVO;
          timer_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INACTIVO;
      timer_q  <= '0;
      seco_q   <= 1'b0;
      alarma_q <= 1'b0;
      riegos_q <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      seco_q   <= seco_d;
      alarma_q <= alarma_d;
      riegos_q <= riegos_d;
    end
  end

  // The request lasts exactly the single PULSO cycle and drops with the sensor.
  assign bus.regar         = bus.MODsensor && (estado_q == PULSO);
  assign bus.humedad_media = media;
  assign bus.alarma        = alarma_q;
  assign bus.riegos        = riegos_q;

endmodule

// File: tb/tb_control_humedad.sv
// Self-checking bench for control_humedad: directed scenarios plus random
// sample rounds compared against a per-round behavioural model.
module tb_control_humedad;

  localparam int ACK    = 8;
  localparam int REPOSO = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  control_humedad_if bus();

  control_humedad #(
    .ACK_CICLOS    (ACK),
    .REPOSO_CICLOS (64'(REPOSO))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   regar_cnt = 0;
  int   last_regar_cyc = -1;
  int   alarma_cyc = -1;
  logic regar_prev = 1'b0;

  bit   seco_m = 1'b0;
  bit   alarma_m = 1'b0;
  int   riegos_m = 0;

  byte unsigned muestras[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Watering-request monitor: counts pulses and rejects back-to-back requests.
  always @(negedge clk) begin
    if (bus.regar === 1'b1) begin
      checks++;
      assert (regar_prev !== 1'b1) else begin
        errors++;
        $error("FAIL regar_consecutivo observed=1 expected=0");
      end
      regar_cnt++;
      last_regar_cyc = cyc;
    end
    regar_prev = bus.regar;
    if (bus.alarma === 1'b1 && alarma_cyc < 0) alarma_cyc = cyc;
  end

  task automatic modelo(output int media_e, output bit regar_e);
    int suma = 0;
    int n = 0;
    foreach (muestras[i]) begin
      if (muestras[i] <= 100 && n < 4) begin
        suma += muestras[i];
        n++;
      end
    end
    media_e = suma / 4;
    regar_e = (media_e < 20) || (seco_m && media_e < 40);
    if (media_e < 20)       seco_m = 1'b1;
    else if (media_e >= 40) seco_m = 1'b0;
  endtask

  task automatic enviar();
    foreach (muestras[i]) begin
      @(negedge clk);
      bus.humedad        = muestras[i];
      bus.humedad_valida = 1'b1;
      @(negedge clk);
      bus.humedad_valida = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic esperar_regar(input int antes, output bit visto);
    visto = 1'b0;
    for (int i = 0; i < 12 && !visto; i++) begin
      @(negedge clk);
      if (regar_cnt != antes) visto = 1'b1;
    end
  endtask

  task automatic ronda(input string tag, input int bomba_delay);
    int media_e;
    bit regar_e;
    bit visto;
    int antes;
    modelo(media_e, regar_e);
    antes = regar_cnt;
    enviar();
    esperar_regar(antes, visto);
    if (visto && bomba_delay >= 0) begin
      repeat (bomba_delay) @(negedge clk);
      bus.bomba_activa = 1'b1;
      repeat (2) @(negedge clk);
      bus.bomba_activa = 1'b0;
    end
    if (regar_e) begin
      if (bomba_delay < 0) alarma_m = 1'b1;
      if (riegos_m < 255) riegos_m++;
      // Dry-looking samples during the soak lockout must leave no trace.
      repeat (20) @(negedge clk);
      muestras = '{5, 5, 5, 5};
      enviar();
      repeat (ACK + REPOSO) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    chk({tag, " media"},  bus.humedad_media, 64'(media_e));
    chk({tag, " regar"},  64'(regar_cnt - antes), 64'(regar_e));
    chk({tag, " riegos"}, bus.riegos, 64'(riegos_m));
    chk({tag, " alarma"}, bus.alarma, 64'(alarma_m));
  endtask

  initial begin
    int  media_e;
    bit  regar_e;
    bit  visto;
    int  antes;
    int  base;
    int  retardo;

    bus.humedad        = 8'd0;
    bus.humedad_valida = 1'b0;
    bus.MODsensor      = 1'b0;
    bus.bomba_activa   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset regar",  bus.regar, 0);
    chk("reset media",  bus.humedad_media, 0);
    chk("reset alarma", bus.alarma, 0);
    chk("reset riegos", bus.riegos, 0);

    rst_n = 1'b1;
    bus.MODsensor = 1'b1;
    repeat (3) @(negedge clk);

    muestras = '{50, 50, 50, 50};
    ronda("r031", 2);
    muestras = '{10, 12, 14, 16};
    ronda("r032", 3);
    muestras = '{10, 10, 10, 10};
    ronda("r033", -1);
    chk("r033 alarma_latencia", 64'(alarma_cyc - last_regar_cyc), 64'(ACK + 1));

    muestras = '{30, 30, 30, 30};
    ronda("r034a", 1);
    muestras = '{45, 45, 45, 45};
    ronda("r034b", 1);
    muestras = '{30, 30, 30, 30};
    ronda("r034c", 1);

    muestras = '{10, 200, 10, 10, 10};
    ronda("r035a", 2);

    // Partial window, then sensor unplugged with a coincident strobe.
    muestras = '{60, 60};
    enviar();
    @(negedge clk);
    bus.humedad        = 8'd0;
    bus.humedad_valida = 1'b1;
    bus.MODsensor      = 1'b0;
    @(negedge clk);
    bus.humedad_valida = 1'b0;
    repeat (2) @(negedge clk);
    bus.MODsensor = 1'b1;
    repeat (3) @(negedge clk);
    muestras = '{80, 80, 80, 80};
    ronda("r035b", 2);

    for (int r = 0; r < 8; r++) begin
      base = $urandom_range(0, 60);
      muestras.delete();
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) muestras.push_back(8'($urandom_range(101, 255)));
        muestras.push_back(8'(base + $urandom_range(0, 10)));
      end
      retardo = int'($urandom_range(0, 5)) - 1;
      ronda($sformatf("rnd%0d", r), retardo);
    end

    // Asynchronous reset in the middle of the soak lockout.
    muestras = '{5, 5, 5, 5};
    modelo(media_e, regar_e);
    antes = regar_cnt;
    enviar();
    esperar_regar(antes, visto);
    chk("r036 regar_previo", 64'(visto), 64'(regar_e));
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("r036 regar",  bus.regar, 0);
    chk("r036 media",  bus.humedad_media, 0);
    chk("r036 alarma", bus.alarma, 0);
    chk("r036 riegos", bus.riegos, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    seco_m   = 1'b0;
    alarma_m = 1'b0;
    riegos_m = 0;
    antes = regar_cnt;
    repeat (20) @(negedge clk);
    chk("r036 sin_pendiente", 64'(regar_cnt - antes), 0);
    muestras = '{30, 30, 30, 30};
    ronda("r036b", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_humedad.md
CONTROL_HUMEDAD -- requirements
Module: control_humedad

Interface
REQ-001 Parameter UMBRAL_BAJO, default 20: humidity percent below which watering is requested.
REQ-002 Parameter UMBRAL_ALTO, default 40: humidity percent at or above which the dry condition clears (hysteresis).
REQ-003 Parameter ACK_CICLOS, default 16: cycles allowed for pump acknowledge after a watering pulse.
REQ-004 Parameter REPOSO_CICLOS, default 3_000_000_000: soak lockout after watering (60 s at 50 MHz).
REQ-005 clk  in  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 humedad  in  8  sensor humidity sample, percent.
REQ-008 humedad_valida  in  1  one-cycle strobe qualifying humedad.
REQ-009 MODsensor  in  1  high when the humidity sensor module is connected.
REQ-010 bomba_activa  in  1  pump-running feedback from the downstream pump stage.
REQ-011 regar  out  1  one-cycle watering request to the downstream pump stage.
REQ-012 humedad_media  out  8  last computed 4-sample average.
REQ-013 alarma  out  1  sticky pump-not-responding flag.
REQ-014 riegos  out  8  saturating count of watering requests issued.

Function
REQ-015 Samples with humedad_valida=1 and humedad<=100 SHALL be accumulated; samples >100 SHALL be discarded and not counted.
REQ-016 After the 4th accepted sample, the block SHALL register humedad_media = (sum of 4, 10-bit) >> 2 (truncating) on the following cycle and clear the accumulator and sample count.
REQ-017 FSM states: INACTIVO, MUESTREO, PULSO, ESPERA_ACK, REPOSO.
REQ-018 INACTIVO -> MUESTREO when MODsensor=1; any state -> INACTIVO when MODsensor=0, clearing accumulator, sample count and regar in that cycle.
REQ-019 In MUESTREO, when a new average is registered: set internal flag seco if media<UMBRAL_BAJO; clear seco if media>=UMBRAL_ALTO.
REQ-020 In MUESTREO, a new average with media<UMBRAL_BAJO, or with seco=1 and media<UMBRAL_ALTO, SHALL cause transition to PULSO on the next cycle.
REQ-021 PULSO: regar=1 for exactly one cycle, riegos increments (saturating at 255), then ESPERA_ACK.
REQ-022 ESPERA_ACK: on bomba_activa=1 within ACK_CICLOS cycles go to REPOSO; on expiry set alarma=1 and go to REPOSO.
REQ-023 REPOSO: count REPOSO_CICLOS cycles (64-bit counter), then return to MUESTREO with an empty accumulator; samples arriving in PULSO, ESPERA_ACK, REPOSO SHALL be ignored.
REQ-024 regar SHALL never be high in two consecutive cycles nor in any state other than PULSO.
REQ-025 humedad_valida coincident with MODsensor falling SHALL be ignored.
REQ-026 alarma SHALL remain set until reset; it does not block further watering.

Reset
REQ-027 rst_n=0 SHALL immediately force: state INACTIVO, regar=0, alarma=0, humedad_media=0, riegos=0, seco=0, accumulator, sample count and all timers 0.
REQ-028 Reset deassertion mid-watering SHALL restart from INACTIVO with no pending request.

Structure
REQ-029 Package riego_pkg SHALL hold the FSM state enum and default threshold constants (20, 40) shared with the pump stage.
REQ-030 Averaging (REQ-015/016) SHALL be a sub-module promedio_humedad with outputs media[7:0] and media_lista strobe.

Verification (ACK_CICLOS=8, REPOSO_CICLOS=100)
REQ-031 MODsensor=1, samples 50,50,50,50 -> humedad_media=50, no regar, riegos=0.
REQ-032 Samples 10,12,14,16 with bomba_activa raised 3 cycles after regar -> media=13, single regar pulse, riegos=1, alarma=0, next 100 cycles no regar.
REQ-033 Samples 10x4, bomba_activa held 0 -> regar once, alarma=1 exactly 8 cycles after ESPERA_ACK entry, stays 1.
REQ-034 After dry event, samples 30x4 post-REPOSO -> second regar (hysteresis); then 45x4 -> seco cleared, subsequent 30x4 -> no regar.
REQ-035 Samples 10,200,10,10,10 -> 200 discarded, media=10; MODsensor dropped after 2 samples -> counter cleared, next 4 samples form a fresh average.
REQ-036 rst_n pulsed low during REPOSO -> all outputs 0 asynchronously, FSM in INACTIVO.
